// File: rtl/instr_assembler_pkg.sv
// -----------------------------------------------------------------------------
// instr_assembler_pkg
// Shared definitions for the instruction assembler:
//   - instruction field widths and bit positions of the 32-bit MIPS-style word
//   - R-type opcode constant
//   - FSM state encoding (also exported on the debug state port)
// -----------------------------------------------------------------------------
package instr_assembler_pkg;

    localparam int INSTR_W  = 32;
    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    // Every R-type instruction carries opcode 0; the operation lives in funct.
    localparam logic [OPCODE_W-1:0] OPCODE_RTYPE = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } asm_state_e;

endpackage

// File: rtl/instr_assembler_if.sv
// -----------------------------------------------------------------------------
// instr_assembler_if
// Bundles the field-tuple input handshake and the memory write port.
//   Tuple side : in_valid, in_ready, in_rtype, opcode, rs, rt, rd, shamt,
//                funct, immediate
//   Write side : wr_en, wr_addr, wr_data, wr_ack
// Modports:
//   master - environment: offers tuples and acknowledges memory writes
//   slave  - the assembler
//
// Handshake rules: a tuple is transferred on a rising edge where in_valid and
// in_ready are both high. A write is transferred on a rising edge where wr_en
// and wr_ack are both high; wr_en/wr_addr/wr_data do not change until then.
// -----------------------------------------------------------------------------
interface instr_assembler_if
    import instr_assembler_pkg::*;
#(
    parameter int ADDR_W = 4
);
    logic                in_valid;
    logic                in_ready;
    logic                in_rtype;
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    shamt;
    logic [FUNCT_W-1:0]  funct;
    logic [IMM_W-1:0]    immediate;

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [INSTR_W-1:0]  wr_data;
    logic                wr_ack;

    modport master (
        output in_valid, in_rtype, opcode, rs, rt, rd, shamt, funct, immediate,
        output wr_ack,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_rtype, opcode, rs, rt, rd, shamt, funct, immediate,
        input  wr_ack,
        output in_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/instr_assembler_field_packer.sv
// -----------------------------------------------------------------------------
// instr_field_packer
// Combinational encoder: instruction fields + format select -> 32-bit word.
// Inverse of the field decoder.
//   rtype_i   1 = R-type {opcode, rs, rt, rd, shamt, funct}
//             0 = I-type {opcode, rs, rt, immediate}
//   opcode_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i   field inputs
//   word_o    encoded instruction
// -----------------------------------------------------------------------------
module instr_field_packer
    import instr_assembler_pkg::*;
(
    input  logic                rtype_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [REG_W-1:0]    rs_i,
    input  logic [REG_W-1:0]    rt_i,
    input  logic [REG_W-1:0]    rd_i,
    input  logic [REG_W-1:0]    shamt_i,
    input  logic [FUNCT_W-1:0]  funct_i,
    input  logic [IMM_W-1:0]    imm_i,
    output logic [INSTR_W-1:0]  word_o
);

    always_comb begin
        word_o = '0;
        word_o[OPCODE_MSB:OPCODE_LSB] = opcode_i;
        word_o[RS_MSB:RS_LSB]         = rs_i;
        word_o[RT_MSB:RT_LSB]         = rt_i;
        if (rtype_i) begin
            word_o[RD_MSB:RD_LSB]       = rd_i;
            word_o[SHAMT_MSB:SHAMT_LSB] = shamt_i;
            word_o[FUNCT_MSB:FUNCT_LSB] = funct_i;
        end else begin
            // The low half is shared: rd/shamt/funct are ignored for I-type.
            word_o[IMM_MSB:IMM_LSB] = imm_i;
        end
    end

endmodule

// File: rtl/instr_assembler.sv
// -----------------------------------------------------------------------------
// instr_assembler
// Accepts instruction field tuples, encodes them into 32-bit words and writes
// them to consecutive addresses of an instruction memory of 2^ADDR_W words.
//
// Parameters:
//   ADDR_W      memory address width
//   START_ADDR  first write address after reset or clear
// Ports:
//   clock_i   rising-edge clock
//   reset_ni  asynchronous active-low reset
//   clear_i   synchronous restart of the write sequence (overrides all inputs)
//   bus       instr_assembler_if.slave (tuple handshake + memory write port)
//   count_o   words written since reset/clear
//   full_o    count_o == 2^ADDR_W
//   error_o   sticky illegal-tuple flag (0 unless ASM_CHECK_EN)
//   state_o   current FSM state (debug)
//
// Build option: define ASM_CHECK_EN to reject R-type tuples with a non-zero
// opcode (sets error_o, tuple discarded). Without it every tuple is written.
// -----------------------------------------------------------------------------
module instr_assembler
    import instr_assembler_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int START_ADDR = 0
) (
    input  logic               clock_i,
    input  logic               reset_ni,
    input  logic               clear_i,
    instr_assembler_if.slave   bus,
    output logic [ADDR_W:0]    count_o,
    output logic               full_o,
    output logic               error_o,
    output asm_state_e         state_o
);

`ifdef ASM_CHECK_EN
    localparam bit CheckEn = 1'b1;
`else
    localparam bit CheckEn = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] StartAddr = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W:0]   Depth     = (ADDR_W+1)'(1) << ADDR_W;

    asm_state_e         state_q;
    logic               in_ready_q;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [INSTR_W-1:0] wr_data_q;
    logic [ADDR_W:0]    count_q;
    logic               full_q;
    logic               error_q;

    logic [ADDR_W:0]    count_d;
    logic [ADDR_W-1:0]  wr_addr_d;
    logic [INSTR_W-1:0] packed_word;
    logic               tuple_illegal;

    instr_field_packer u_packer (
        .rtype_i  (bus.in_rtype),
        .opcode_i (bus.opcode),
        .rs_i     (bus.rs),
        .rt_i     (bus.rt),
        .rd_i     (bus.rd),
        .shamt_i  (bus.shamt),
        .funct_i  (bus.funct),
        .imm_i    (bus.immediate),
        .word_o   (packed_word)
    );

    // Address wraps naturally modulo 2^ADDR_W; fullness is judged on count only.
    assign count_d       = count_q + (ADDR_W+1)'(1);
    assign wr_addr_d     = wr_addr_q + ADDR_W'(1);
    assign tuple_illegal = CheckEn && bus.in_rtype && (bus.opcode != OPCODE_RTYPE);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= StartAddr;
            wr_data_q  <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            error_q    <= 1'b0;
        end else if (clear_i) begin
            // Abandons any pending write; no tuple is taken in this cycle.
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= StartAddr;
            count_q    <= '0;
            full_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (tuple_illegal) begin
                            error_q <= 1'b1;
                        end else begin
                            wr_data_q  <= packed_word;
                            wr_en_q    <= 1'b1;
                            in_ready_q <= 1'b0;
                            state_q    <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.wr_ack) begin
                        wr_en_q   <= 1'b0;
                        count_q   <= count_d;
                        wr_addr_q <= wr_addr_d;
                        if (count_d == Depth) begin
                            full_q  <= 1'b1;
                            state_q <= ST_FULL;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end
                    end
                end
                ST_FULL: begin
                    // Parked until clear or reset.
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
                    wr_en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign count_o      = count_q;
    assign full_o       = full_q;
    assign error_o      = error_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_instr_assembler.sv
// -----------------------------------------------------------------------------
// tb_instr_assembler
// Directed table-driven bench for instr_assembler (ADDR_W=4, START_ADDR=0),
// followed by hand-written sequences for fill/full, clear, reset and the
// optional ASM_CHECK_EN behaviour.
// -----------------------------------------------------------------------------
module tb_instr_assembler;
    import instr_assembler_pkg::*;

    localparam int ADDR_W = 4;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic [ADDR_W:0]  count;
    logic             full;
    logic             error;
    asm_state_e       state;

    instr_assembler_if #(.ADDR_W(ADDR_W)) bus ();

    instr_assembler #(.ADDR_W(ADDR_W), .START_ADDR(0)) dut (
        .clock_i  (clk),
        .reset_ni (rst_n),
        .clear_i  (clear),
        .bus      (bus),
        .count_o  (count),
        .full_o   (full),
        .error_o  (error),
        .state_o  (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [ADDR_W-1:0] exp_addr;
    logic [ADDR_W:0]   exp_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic        rtype;
        logic [5:0]  opcode;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        int          ack_dly;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[6];

    // ---------------- driver tasks ----------------
    task automatic drive_fields(input vec_t v);
        bus.in_rtype  = v.rtype;
        bus.opcode    = v.opcode;
        bus.rs        = v.rs;
        bus.rt        = v.rt;
        bus.rd        = v.rd;
        bus.shamt     = v.shamt;
        bus.funct     = v.funct;
        bus.immediate = v.imm;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic handshake(input vec_t v);
        int waited;
        waited = 0;
        drive_fields(v);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("hs_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic ack_now();
        bus.wr_ack = 1'b1;
        @(posedge clk); #1;
        bus.wr_ack = 1'b0;
    endtask

    task automatic write_word(input vec_t v, input string tag);
        handshake(v);
        chk({tag, "_wr_en"},   32'(bus.wr_en),   32'd1);
        chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'(exp_addr));
        chk({tag, "_wr_data"}, bus.wr_data,      v.exp_word);
        for (int d = 0; d < v.ack_dly; d++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_en"},   32'(bus.wr_en),   32'd1);
            chk({tag, "_hold_data"}, bus.wr_data,      v.exp_word);
            chk({tag, "_hold_addr"}, 32'(bus.wr_addr), 32'(exp_addr));
        end
        ack_now();
        exp_count++;
        exp_addr++;
        chk({tag, "_en_drop"}, 32'(bus.wr_en), 32'd0);
        chk({tag, "_count"},   32'(count),     32'(exp_count));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        exp_count = '0;
        exp_addr  = '0;
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t v;
        vec_t f;

        //          rt op     rs  rt  rd  sh  funct  imm      dly exp
        vecs[0] = '{1'b1, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'h0000, 0, 32'h00221820};
        vecs[1] = '{1'b0, 6'h08, 5'd1,  5'd2,  5'd0,  5'd0,  6'h00, 16'h0005, 3, 32'h20220005};
        vecs[2] = '{1'b1, 6'h00, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h0000, 1, 32'h03FFFFFF};
        vecs[3] = '{1'b0, 6'h3F, 5'd0,  5'd0,  5'd7,  5'd9,  6'h15, 16'hFFFF, 0, 32'hFC00FFFF};
        vecs[4] = '{1'b0, 6'h23, 5'd29, 5'd8,  5'd0,  5'd0,  6'h00, 16'h0010, 2, 32'h8FA80010};
        vecs[5] = '{1'b1, 6'h00, 5'd4,  5'd5,  5'd6,  5'd2,  6'h02, 16'h0000, 0, 32'h00853082};

        bus.in_valid = 1'b0;
        bus.wr_ack   = 1'b0;
        drive_fields(vecs[0]);
        clear     = 1'b0;
        rst_n     = 1'b0;
        exp_addr  = '0;
        exp_count = '0;

        // Reset state, checked while reset is held.
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_wr_en",    32'(bus.wr_en),    32'd0);
        chk("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
        chk("rst_wr_data",  bus.wr_data,       32'd0);
        chk("rst_count",    32'(count),        32'd0);
        chk("rst_full",     32'(full),         32'd0);
        chk("rst_error",    32'(error),        32'd0);
        chk("rst_state",    32'(state),        32'(ST_IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven writes.
        for (int i = 0; i < 6; i++) begin
            write_word(vecs[i], $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_ready", i), 32'(bus.in_ready), 32'd1);
        end

        // wr_ack outside WRITE is ignored.
        ack_now();
        chk("idle_ack_count", 32'(count),     32'(exp_count));
        chk("idle_ack_addr",  32'(bus.wr_addr), 32'(exp_addr));
        chk("idle_ack_state", 32'(state),     32'(ST_IDLE));

        // Fill the remaining 10 words.
        for (int i = 0; i < 10; i++) begin
            f = '{1'b0, 6'h0D, 5'd0, 5'(i), 5'd0, 5'd0, 6'h00, 16'(i * 3),
                  i % 2, {6'h0D, 5'd0, 5'(i), 16'(i * 3)}};
            write_word(f, $sformatf("fill%0d", i));
        end
        chk("full_flag",   32'(full),         32'd1);
        chk("full_ready",  32'(bus.in_ready), 32'd0);
        chk("full_count",  32'(count),        32'd16);
        chk("full_addr",   32'(bus.wr_addr),  32'd0);
        chk("full_state",  32'(state),        32'(ST_FULL));

        // Extra tuples while full are not taken.
        drive_fields(vecs[0]);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("full_no_wr", 32'(bus.wr_en), 32'd0);
        end
        bus.in_valid = 1'b0;
        ack_now();
        chk("full_hold_count", 32'(count), 32'd16);

        do_clear();
        chk("clr_count", 32'(count),         32'd0);
        chk("clr_addr",  32'(bus.wr_addr),   32'd0);
        chk("clr_ready", 32'(bus.in_ready),  32'd1);
        chk("clr_full",  32'(full),          32'd0);
        chk("clr_state", 32'(state),         32'(ST_IDLE));

        // R-type format with a non-zero opcode.
        v = '{1'b1, 6'h08, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 0, 32'h20221820};
`ifdef ASM_CHECK_EN
        handshake(v);
        chk("chk_error", 32'(error),         32'd1);
        chk("chk_wr_en", 32'(bus.wr_en),     32'd0);
        chk("chk_count", 32'(count),         32'(exp_count));
        chk("chk_ready", 32'(bus.in_ready),  32'd1);
        @(posedge clk); #1;
        chk("chk_wr_en2", 32'(bus.wr_en),    32'd0);
        do_clear();
        chk("chk_error_clr", 32'(error),     32'd0);
`else
        write_word(v, "nochk");
        chk("nochk_error", 32'(error), 32'd0);
`endif

        // Clear abandons a pending write even with wr_ack present.
        handshake(vecs[1]);
        chk("abandon_pre_en", 32'(bus.wr_en), 32'd1);
        clear      = 1'b1;
        bus.wr_ack = 1'b1;
        @(posedge clk); #1;
        clear      = 1'b0;
        bus.wr_ack = 1'b0;
        exp_count  = '0;
        exp_addr   = '0;
        chk("abandon_wr_en", 32'(bus.wr_en),    32'd0);
        chk("abandon_count", 32'(count),        32'd0);
        chk("abandon_addr",  32'(bus.wr_addr),  32'd0);
        chk("abandon_ready", 32'(bus.in_ready), 32'd1);

        // Clear wins over a simultaneous valid tuple.
        drive_fields(vecs[0]);
        bus.in_valid = 1'b1;
        clear        = 1'b1;
        @(posedge clk); #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_valid_wr_en", 32'(bus.wr_en), 32'd0);
        chk("clr_valid_state", 32'(state),     32'(ST_IDLE));

        // Write one word so count is non-zero, then reset in the middle of a write.
        write_word(vecs[0], "pre_rst");
        handshake(vecs[4]);
        chk("rst_mid_pre_en", 32'(bus.wr_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_mid_ready", 32'(bus.in_ready), 32'd1);
        #3;
        rst_n = 1'b1;
        exp_count = '0;
        exp_addr  = '0;
        @(posedge clk); #1;
        chk("rst_mid_count", 32'(count),       32'd0);
        chk("rst_mid_addr",  32'(bus.wr_addr), 32'd0);

        // Following write decoded field by field.
        v = '{1'b1, 6'h00, 5'd17, 5'd9, 5'd21, 5'd5, 6'h2A, 16'h0000, 0, 32'h0229A96A};
        handshake(v);
        chk("dec_opcode", 32'(bus.wr_data[31:26]), 32'(v.opcode));
        chk("dec_rs",     32'(bus.wr_data[25:21]), 32'(v.rs));
        chk("dec_rt",     32'(bus.wr_data[20:16]), 32'(v.rt));
        chk("dec_rd",     32'(bus.wr_data[15:11]), 32'(v.rd));
        chk("dec_shamt",  32'(bus.wr_data[10:6]),  32'(v.shamt));
        chk("dec_funct",  32'(bus.wr_data[5:0]),   32'(v.funct));
        chk("dec_word",   bus.wr_data,             v.exp_word);
        ack_now();
        chk("dec_count",  32'(count),              32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_assembler.md
INSTR_ASSEMBLER -- requirements
Module: instr_assembler

Interface
REQ-001 Parameter: ADDR_W, default 4, instruction-memory address width; depth = 2^ADDR_W words.
REQ-002 Parameter: START_ADDR, default 0, first write address after reset or clear.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous restart of the write sequence.
REQ-007 in_valid  input  1  field tuple offered.
REQ-008 in_ready  output  1  block accepts a tuple this cycle.
REQ-009 in_rtype  input  1  1 = R-type format, 0 = I-type format.
REQ-010 opcode  input  6, rs/rt/rd/shamt  input  5 each, funct  input  6, immediate  input  16  instruction fields.
REQ-011 wr_en  output  1  memory write request.
REQ-012 wr_addr  output  ADDR_W  write address.
REQ-013 wr_data  output  32  encoded instruction word.
REQ-014 wr_ack  input  1  memory accepted the write.
REQ-015 count  output  ADDR_W+1  words written since reset/clear.
REQ-016 full  output  1  count == 2^ADDR_W.
REQ-017 error  output  1  sticky illegal-tuple flag (see Configuration).

Function
REQ-018 R-type word SHALL be {opcode, rs, rt, rd, shamt, funct}; I-type word SHALL be {opcode, rs, rt, immediate}; rd/shamt/funct ignored for I-type.
REQ-019 FSM states: IDLE, WRITE, FULL.
REQ-020 IDLE: in_ready=1, wr_en=0; handshake (in_valid & in_ready) at edge N SHALL register the encoded word into wr_data and enter WRITE, so wr_en=1 from cycle N+1.
REQ-021 WRITE: in_ready=0; wr_en, wr_addr and wr_data SHALL hold stable until wr_ack is sampled high.
REQ-022 wr_ack high in WRITE at edge M: wr_en=0, count+1 and wr_addr+1 (mod 2^ADDR_W) after edge M; next state FULL if new count == 2^ADDR_W, else IDLE.
REQ-023 wr_ack while not in WRITE SHALL be ignored.
REQ-024 FULL: in_ready=0, wr_en=0, full=1; exit only via clear or reset.
REQ-025 wr_addr SHALL wrap from 2^ADDR_W-1 to 0 when START_ADDR != 0; full is determined by count only.
REQ-026 clear SHALL override every other input: next state IDLE, wr_addr=START_ADDR, count=0, error=0, pending write abandoned (wr_en=0 next cycle), no handshake in that cycle.
REQ-027 Throughput: at most one word per two cycles (accept, ack).

Reset
REQ-028 reset low SHALL immediately force: state IDLE, in_ready=1 (deassert-time), wr_en=0, wr_addr=START_ADDR, wr_data=0, count=0, full=0, error=0.
REQ-029 reset mid-WRITE SHALL drop wr_en asynchronously; the in-flight word is lost.

Configuration
REQ-030 Macro ASM_CHECK_EN defined: handshake with in_rtype=1 and opcode != 0 SHALL set error, discard the tuple, remain in IDLE, count unchanged.
REQ-031 Macro ASM_CHECK_EN undefined: no check; error tied to 0; every tuple is encoded and written.

Structure
REQ-032 Shared package holds: field widths and bit positions (opcode 31:26, rs 25:21, rt 20:16, rd 15:11, shamt 10:6, funct 5:0, imm 15:0), FSM state encoding, R-type opcode constant 0.
REQ-033 One combinational sub-module instr_field_packer (fields + in_rtype -> 32-bit word), the inverse of the existing field decoder; FSM, counters and registers in instr_assembler.

Verification
REQ-034 R-type opcode 0, rs 1, rt 2, rd 3, shamt 0, funct 0x20, wr_ack next cycle -> wr_addr 0, wr_data 0x00221820, count 1.
REQ-035 I-type opcode 0x08, rs 1, rt 2, imm 5 -> wr_data 0x20220005 at the next wr_addr; wr_en held 3 cycles while wr_ack is delayed 3 cycles, data stable.
REQ-036 16 acked writes -> full=1, in_ready=0, count 16; extra in_valid ignored; clear -> count 0, wr_addr 0, in_ready=1.
REQ-037 reset low during WRITE with wr_ack never given -> wr_en 0 immediately, count 0 after release; decoded readback of a following write matches the fed fields.
REQ-038 ASM_CHECK_EN: in_rtype 1, opcode 0x08 -> error=1, wr_en stays 0, count unchanged; without macro -> wr_data 0x20221820 written.
